// File: rtl/cpu_pkg.sv
// Shared CPU definitions: cpustate encodings and default memory geometry.
// Used by the program loader and the control unit alike.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IN    = 2'b01,
        ST_CHECK = 2'b10,
        ST_RUN   = 2'b11
    } cpustate_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory port of the loader.
// The loader drives the master side; source and memory sit on the slave side.
interface prog_loader_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
    parameter int DATA_W = cpu_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  din, din_valid, mem_rdata,
        output din_ready, mem_sel, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport slave (
        output din, din_valid, mem_rdata,
        input  din_ready, mem_sel, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/edge_det.sv
// Rising-edge detector: registers the input level and pulses for one cycle
// on a 0->1 transition.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic sig_q;
    logic sig_d;

    always_comb sig_d = sig;

    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_d;
    end

    assign rise = sig & ~sig_q;
endmodule

// File: rtl/prog_loader.sv
// Program memory front end: streams bytes in (IN), reads them back one per
// step (CHECK), and hands the memory port to the CPU otherwise.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpustate,
    input  logic              step,
    prog_loader_if.master     bus,
    output logic [ADDR_W-1:0] chk_addr,
    output logic [DATA_W-1:0] chk_data,
    output logic              chk_valid,
    output logic [ADDR_W:0]   load_count,
    output logic              full
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD_WAIT, S_LD_WR, S_CK_RD, S_CK_CAP, S_CK_SHOW
    } state_e;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
    logic [DATA_W-1:0] chk_data_q, chk_data_d;
    logic              chk_valid_q, chk_valid_d;
    logic              step_rise;
    logic              dispatch;

    edge_det u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (step),
        .rise (step_rise)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        chk_addr_d    = chk_addr_q;
        chk_data_d    = chk_data_q;
        chk_valid_d   = chk_valid_q;
        dispatch      = 1'b0;
        bus.din_ready = 1'b0;
        bus.mem_sel   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;

        // dispatch marks points where a cpustate change may be taken; LD_WR
        // and CK_RD/CK_CAP finish their memory access before that happens.
        case (state_q)
            S_IDLE: dispatch = 1'b1;
            S_LD_WAIT: begin
                bus.mem_sel   = 1'b1;
                bus.din_ready = ~cnt_q[ADDR_W];
                if (bus.din_valid && !cnt_q[ADDR_W]) begin
                    byte_d  = bus.din;
                    state_d = S_LD_WR;
                end else begin
                    dispatch = 1'b1;
                end
            end
            S_LD_WR: begin
                bus.mem_sel   = 1'b1;
                bus.mem_write = 1'b1;
                bus.mem_addr  = wptr_q;
                bus.mem_wdata = byte_q;
                wptr_d        = wptr_q + ADDR_W'(1);
                cnt_d         = cnt_q + CNT_ONE;
                state_d       = S_LD_WAIT;
                dispatch      = 1'b1;
            end
            S_CK_RD: begin
                bus.mem_sel  = 1'b1;
                bus.mem_read = 1'b1;
                bus.mem_addr = rptr_q;
                state_d      = S_CK_CAP;
            end
            S_CK_CAP: begin
                bus.mem_sel = 1'b1;
                chk_data_d  = bus.mem_rdata;
                chk_addr_d  = rptr_q;
                chk_valid_d = 1'b1;
                state_d     = S_CK_SHOW;
                dispatch    = 1'b1;
            end
            S_CK_SHOW: begin
                bus.mem_sel = 1'b1;
                if (step_rise && cpustate == ST_CHECK && cnt_q != '0) begin
                    rptr_d  = (({1'b0, rptr_q} + CNT_ONE) == cnt_q) ? '0 : rptr_q + ADDR_W'(1);
                    state_d = S_CK_RD;
                end else begin
                    dispatch = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (dispatch) begin
            case (cpustate)
                ST_IN: begin
                    if (!(state_q inside {S_LD_WAIT, S_LD_WR})) begin
                        wptr_d      = '0;
                        cnt_d       = '0;
                        chk_valid_d = 1'b0;
                        state_d     = S_LD_WAIT;
                    end
                end
                ST_CHECK: begin
                    if (!(state_q inside {S_CK_CAP, S_CK_SHOW})) begin
                        rptr_d      = '0;
                        chk_valid_d = 1'b0;
                        state_d     = (cnt_d == '0) ? S_CK_SHOW : S_CK_RD;
                    end
                end
                default: begin
                    chk_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            chk_addr_q  <= '0;
            chk_data_q  <= '0;
            chk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            chk_addr_q  <= chk_addr_d;
            chk_data_q  <= chk_data_d;
            chk_valid_q <= chk_valid_d;
        end
    end

    assign chk_addr   = chk_addr_q;
    assign chk_data   = chk_data_q;
    assign chk_valid  = chk_valid_q;
    assign load_count = cnt_q;
    assign full       = cnt_q[ADDR_W];
endmodule
